// File: rtl/alu4_arbiter_if.sv
// Requester-side bus of alu4_arbiter: request handshake with operands, response handshake with result/flags.
// Define ALU_LOCK_EN to add the per-requester req_lock signal.
interface alu4_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [3:0]        rsp_result;
  logic [3:0]        rsp_flags;
`ifdef ALU_LOCK_EN
  logic [NREQ-1:0]   req_lock;

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, req_lock, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, req_lock, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );
`else
  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );
`endif
endinterface

// File: rtl/alu4_arbiter.sv
// Round-robin arbiter sharing one combinational 4-bit ALU among NREQ requesters, one op in flight.
// Define ALU_LOCK_EN to let a requester holding req_lock keep priority for back-to-back ops.
module alu4_arbiter #(
  parameter int NREQ = 2
) (
  input  logic          clk,
  input  logic          rst,
  alu4_arbiter_if.slave bus,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [2:0]    alu_c,
  output logic          alu_cin,
  input  logic [3:0]    alu_result,
  input  logic          alu_zero,
  input  logic          alu_ovf,
  input  logic          alu_carry,
  input  logic          alu_size
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     g;
  logic [PW-1:0]     off;
  logic [PW-1:0]     winner;
  logic              found;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [2:0]        sel_op;
  logic [3:0]        sel_a;
  logic [3:0]        sel_b;
  logic              sel_cin;
  logic [2:0]        op_q;
  logic [3:0]        a_q;
  logic [3:0]        b_q;
  logic              cin_q;
  logic              arith_op;
  logic              cmp_op;
`ifdef ALU_LOCK_EN
  logic              sel_lock;
  logic              lock_q;
`endif

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] x, input logic [PW-1:0] y);
    logic [PW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= (PW+1)'(NREQ))
      s = s - (PW+1)'(NREQ);
    return s[PW-1:0];
  endfunction

  // Rotate the request vector so bit 0 is the requester at ptr, then take the lowest set bit.
  always_comb begin
    dbl   = {bus.req_valid, bus.req_valid} >> ptr;
    rot   = dbl[NREQ-1:0];
    off   = '0;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = PW'(k);
        found = 1'b1;
      end
    end
    winner = wrap_add(ptr, off);
  end

  always_comb begin
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
`ifdef ALU_LOCK_EN
    sel_lock = 1'b0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (winner == PW'(k)) begin
        sel_op  = bus.req_op[3*k +: 3];
        sel_a   = bus.req_a[4*k +: 4];
        sel_b   = bus.req_b[4*k +: 4];
        sel_cin = bus.req_cin[k];
`ifdef ALU_LOCK_EN
        sel_lock = bus.req_lock[k];
`endif
      end
    end
  end

  assign bus.req_ready = (state == IDLE && found && !rst) ? (NREQ'(1) << winner) : '0;

  assign alu_a   = (state == EXEC) ? a_q   : 4'd0;
  assign alu_b   = (state == EXEC) ? b_q   : 4'd0;
  assign alu_c   = (state == EXEC) ? op_q  : 3'd0;
  assign alu_cin = (state == EXEC) ? cin_q : 1'b0;

  // Carry/overflow are only meaningful for add, sub and compare; zero/size only for compare.
  assign arith_op = (op_q[2] == op_q[1]);
  assign cmp_op   = op_q[2] & op_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      g              <= '0;
      op_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      cin_q          <= 1'b0;
      bus.rsp_valid  <= '0;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
`ifdef ALU_LOCK_EN
      lock_q         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_q  <= sel_op;
            a_q   <= sel_a;
            b_q   <= sel_b;
            cin_q <= sel_cin;
            g     <= winner;
`ifdef ALU_LOCK_EN
            lock_q <= sel_lock;
`endif
            state <= EXEC;
          end
        end
        EXEC: begin
          bus.rsp_result <= alu_result;
          bus.rsp_flags  <= {alu_zero & cmp_op, alu_ovf & arith_op,
                            alu_carry & arith_op, alu_size & cmp_op};
          bus.rsp_valid  <= NREQ'(1) << g;
          state          <= RESP;
        end
        RESP: begin
          // rsp_valid is one-hot on g, so this only honours the granted requester's ready.
          if (|(bus.rsp_ready & bus.rsp_valid)) begin
            bus.rsp_valid <= '0;
`ifdef ALU_LOCK_EN
            ptr <= lock_q ? g : wrap_add(g, PW'(1));
`else
            ptr <= wrap_add(g, PW'(1));
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu4_arbiter.sv
// Self-checking bench for alu4_arbiter: directed spec scenarios plus randomized ops against a reference model.
// Also builds with ALU_LOCK_EN defined, adding the locked-grant scenario.
module tb_alu4_arbiter;
  localparam int NREQ = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_c;
  logic       alu_cin;
  logic [3:0] alu_result;
  logic       alu_zero;
  logic       alu_ovf;
  logic       alu_carry;
  logic       alu_size;
  logic [3:0] junk;
  logic [7:0] aluRaw;
  int         checkCount = 0;
  int         passCount = 0;
  int         ptrModel = 0;
`ifdef ALU_LOCK_EN
  logic [NREQ-1:0] lockDrive;
`endif

  alu4_arbiter_if #(.NREQ(NREQ)) bus ();

  alu4_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_ovf    (alu_ovf),
    .alu_carry  (alu_carry),
    .alu_size   (alu_size)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {zero, ovf, carry, size, result}; flags with no meaning for an op are 0.
  function automatic logic [7:0] refOp(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic cin);
    logic [4:0] s;
    logic [3:0] r;
    logic z, o, c, sz;
    s = '0; r = '0; z = 1'b0; o = 1'b0; c = 1'b0; sz = 1'b0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b} + 5'(cin);
        r = s[3:0];
        c = s[4];
        o = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'b001, 3'b110, 3'b111: begin
        s = {1'b0, a} + {1'b0, ~b} + 5'(cin);
        r = s[3:0];
        c = s[4];
        o = (a[3] != b[3]) && (r[3] != a[3]);
        if (op[2]) begin
          z  = (r == 4'd0);
          sz = (a >= b);
        end
      end
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      default: r = ~a;
    endcase
    return {z, o, c, sz, r};
  endfunction

  // The modelled ALU drives junk on flags it does not define, so the arbiter's mask is exercised.
  always_comb begin
    aluRaw     = refOp(alu_c, alu_a, alu_b, alu_cin);
    alu_result = aluRaw[3:0];
    alu_zero   = (alu_c[2:1] == 2'b11)    ? aluRaw[7] : junk[3];
    alu_ovf    = (alu_c[2] == alu_c[1])   ? aluRaw[6] : junk[2];
    alu_carry  = (alu_c[2] == alu_c[1])   ? aluRaw[5] : junk[1];
    alu_size   = (alu_c[2:1] == 2'b11)    ? aluRaw[4] : junk[0];
  end

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] vmask, input logic [3*NREQ-1:0] ops,
                               input logic [4*NREQ-1:0] as, input logic [4*NREQ-1:0] bs,
                               input logic [NREQ-1:0] cins);
    bus.req_valid = vmask;
    bus.req_op    = ops;
    bus.req_a     = as;
    bus.req_b     = bs;
    bus.req_cin   = cins;
`ifdef ALU_LOCK_EN
    bus.req_lock  = lockDrive;
`endif
  endtask

  // Runs one transaction from IDLE; stall = cycles of held-off rsp_ready in RESP.
  task automatic runOp(input logic [NREQ-1:0] vmask, input logic [3*NREQ-1:0] ops,
                       input logic [4*NREQ-1:0] as, input logic [4*NREQ-1:0] bs,
                       input logic [NREQ-1:0] cins, input int stall,
                       output int grant, output logic [3:0] res, output logic [3:0] flg);
    int w;
    int vm;
    logic [2:0] eop;
    logic [3:0] ea, eb;
    logic ecin;
    logic [7:0] expv;
    logic [NREQ-1:0] oneHot;
`ifdef ALU_LOCK_EN
    bit lockBit;
`endif
    grant = -1; res = '0; flg = '0;
    applyStimulus(vmask, ops, as, bs, cins);
    bus.rsp_ready = '0;
    vm = int'(vmask);
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && ((vm >> ((ptrModel + k) % NREQ)) & 1) == 1) w = (ptrModel + k) % NREQ;
    #1;
    if (w < 0) begin
      checkOutput("idle_ready", 8'(bus.req_ready), 8'd0);
      @(negedge clk);
      #1;
      checkOutput("idle_alu_c", 8'(alu_c), 8'd0);
      return;
    end
    eop  = 3'(ops >> (3*w));
    ea   = 4'(as >> (4*w));
    eb   = 4'(bs >> (4*w));
    ecin = 1'(cins >> w);
    expv = refOp(eop, ea, eb, ecin);
    oneHot = NREQ'(1) << w;
`ifdef ALU_LOCK_EN
    lockBit = ((int'(lockDrive) >> w) & 1) == 1;
`endif
    checkOutput("req_ready", 8'(bus.req_ready), 8'(oneHot));
    @(negedge clk);
    applyStimulus(NREQ'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), NREQ'($urandom));
    #1;
    checkOutput("exec_alu_a", 8'(alu_a), 8'(ea));
    checkOutput("exec_alu_b", 8'(alu_b), 8'(eb));
    checkOutput("exec_alu_c", 8'(alu_c), 8'(eop));
    checkOutput("exec_alu_cin", 8'(alu_cin), 8'(ecin));
    checkOutput("exec_ready", 8'(bus.req_ready), 8'd0);
    checkOutput("exec_rsp_valid", 8'(bus.rsp_valid), 8'd0);
    @(negedge clk);
    res = bus.rsp_result;
    flg = bus.rsp_flags;
    for (int s = 0; s <= stall; s++) begin
      bus.req_valid = NREQ'($urandom);
      #1;
      checkOutput("rsp_valid", 8'(bus.rsp_valid), 8'(oneHot));
      checkOutput("rsp_result", 8'(bus.rsp_result), 8'(expv[3:0]));
      checkOutput("rsp_flags", 8'(bus.rsp_flags), 8'(expv[7:4]));
      checkOutput("resp_ready", 8'(bus.req_ready), 8'd0);
      checkOutput("resp_alu_a", 8'(alu_a), 8'd0);
      if (s < stall) bus.rsp_ready = NREQ'($urandom) & ~oneHot;
      else           bus.rsp_ready = oneHot | NREQ'($urandom);
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    #1;
    checkOutput("done_rsp_valid", 8'(bus.rsp_valid), 8'd0);
`ifdef ALU_LOCK_EN
    ptrModel = lockBit ? w : (w + 1) % NREQ;
`else
    ptrModel = (w + 1) % NREQ;
`endif
    grant = w;
  endtask

  task automatic resetMidOp(input bit inResp);
    applyStimulus(2'b01, 6'b000_000, 8'h07, 8'h01, 2'b00);
    bus.rsp_ready = '0;
    @(negedge clk);
    if (inResp) @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b1;
    #1;
    checkOutput("rst_rsp_valid", 8'(bus.rsp_valid), 8'd0);
    checkOutput("rst_rsp_result", 8'(bus.rsp_result), 8'd0);
    checkOutput("rst_rsp_flags", 8'(bus.rsp_flags), 8'd0);
    checkOutput("rst_alu_a", 8'(alu_a), 8'd0);
    checkOutput("rst_alu_c", 8'(alu_c), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    ptrModel = 0;
    @(negedge clk);
    #1;
    checkOutput("rst_no_response", 8'(bus.rsp_valid), 8'd0);
  endtask

  initial begin
    int gnt;
    logic [3:0] r, f;
    rst = 1'b0;
    junk = 4'hF;
    bus.rsp_ready = '0;
`ifdef ALU_LOCK_EN
    lockDrive = '0;
`endif
    applyStimulus('0, '0, '0, '0, '0);
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_rsp_valid", 8'(bus.rsp_valid), 8'd0);
    checkOutput("reset_rsp_result", 8'(bus.rsp_result), 8'd0);
    checkOutput("reset_rsp_flags", 8'(bus.rsp_flags), 8'd0);
    checkOutput("reset_req_ready", 8'(bus.req_ready), 8'd0);
    checkOutput("reset_alu", 8'({alu_a, alu_cin, alu_c}), 8'd0);
    checkOutput("reset_alu_b", 8'(alu_b), 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] single add");
    runOp(2'b01, 6'b000_000, 8'h07, 8'h01, 2'b00, 0, gnt, r, f);
    checkOutput("t1_grant", 8'(gnt), 8'd0);
    checkOutput("t1_result", 8'(r), 8'h8);
    checkOutput("t1_flags", 8'(f), 8'b0100);

    $display("[TB] logic op masking");
    runOp(2'b10, 6'b011_000, 8'h50, 8'h30, 2'b00, 0, gnt, r, f);
    checkOutput("logic_grant", 8'(gnt), 8'd1);
    checkOutput("logic_result", 8'(r), 8'h7);
    checkOutput("logic_flags", 8'(f), 8'b0000);

    $display("[TB] compares");
    runOp(2'b10, 6'b110_000, 8'h30, 8'h50, 2'b10, 0, gnt, r, f);
    checkOutput("cmp_lt_result", 8'(r), 8'hE);
    checkOutput("cmp_lt_flags", 8'(f), 8'b0000);
    runOp(2'b10, 6'b111_000, 8'h90, 8'h90, 2'b10, 0, gnt, r, f);
    checkOutput("cmp_eq_result", 8'(r), 8'h0);
    checkOutput("cmp_eq_flags", 8'(f), 8'b1011);

    $display("[TB] fairness");
    for (int i = 0; i < 4; i++) begin
      runOp(2'b11, 6'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 0, gnt, r, f);
      checkOutput("fair_grant", 8'(gnt), 8'(i % 2));
    end

    $display("[TB] backpressure");
    runOp(2'b11, 6'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 5, gnt, r, f);
    checkOutput("bp_grant", 8'(gnt), 8'd0);

    $display("[TB] reset mid-op");
    resetMidOp(1'b0);
    runOp(2'b11, 6'b000_000, 8'h02, 8'h03, 2'b00, 0, gnt, r, f);
    checkOutput("post_rst_grant", 8'(gnt), 8'd0);
    checkOutput("post_rst_result", 8'(r), 8'h5);
    resetMidOp(1'b1);
    runOp(2'b00, '0, '0, '0, '0, 0, gnt, r, f);

`ifdef ALU_LOCK_EN
    $display("[TB] locked grant");
    lockDrive = 2'b01;
    for (int i = 0; i < 3; i++) begin
      runOp(2'b11, 6'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 0, gnt, r, f);
      checkOutput("lock_grant", 8'(gnt), 8'd0);
    end
    lockDrive = 2'b00;
    runOp(2'b11, 6'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 0, gnt, r, f);
    checkOutput("unlock_grant", 8'(gnt), 8'd0);
    runOp(2'b11, 6'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 0, gnt, r, f);
    checkOutput("after_unlock_grant", 8'(gnt), 8'd1);
`endif

    $display("[TB] random ops");
    for (int i = 0; i < 40; i++) begin
      junk = 4'($urandom);
`ifdef ALU_LOCK_EN
      lockDrive = NREQ'($urandom);
`endif
      runOp(NREQ'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), NREQ'($urandom),
            int'($urandom_range(0, 3)), gnt, r, f);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
